shift_seq_unit: RTL and testbench

SHIFT_SEQ_UNIT -- requirements
Module: shift_seq_unit

---
 rtl/shift_pkg.sv | 42 ++++
 rtl/shift_step.sv | 45 ++++
 rtl/shift_seq_unit.sv | 102 ++++++++++
 tb/tb_shift_seq_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shifter: opcodes, FSM states,
// the shift-amount width derivation and the opcode legality check.
// Rotates count as legal only when SHIFT_ROTATE_EN is defined.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic int clog2_f(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            OP_SLL, OP_SRL, OP_SRA: return 1'b1;
`ifdef SHIFT_ROTATE_EN
            OP_ROL, OP_ROR:         return 1'b1;
`endif
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves value by k (k <= STEP) positions.
// Rotate paths exist only when SHIFT_ROTATE_EN is defined; any other opcode
// passes the value through unchanged.
module shift_step
    import shift_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int STEP = 1,
    localparam int KW   = clog2_f(STEP) + 1
) (
    input  logic [XLEN-1:0] value,
    input  logic [2:0]      op,
    input  logic [KW-1:0]   k,
    output logic [XLEN-1:0] result
);

`ifdef SHIFT_ROTATE_EN
    logic [2*XLEN-1:0] dbl;
`endif

    // Select the shift flavour; rotates use a doubled word so wrapped bits land in place
    always_comb begin
        result = value;
`ifdef SHIFT_ROTATE_EN
        dbl = '0;
`endif
        case (op)
            OP_SLL: result = value << k;
            OP_SRL: result = value >> k;
            OP_SRA: result = $signed(value) >>> k;
`ifdef SHIFT_ROTATE_EN
            OP_ROL: begin
                dbl    = {value, value} << k;
                result = dbl[2*XLEN-1:XLEN];
            end
            OP_ROR: begin
                dbl    = {value, value} >> k;
                result = dbl[XLEN-1:0];
            end
`endif
            default: result = value;
        endcase
    end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle shifter: accepts one request, shifts up to STEP bits per cycle,
// then holds the result until the consumer takes it.
// Optional rotate support: define SHIFT_ROTATE_EN.
module shift_seq_unit
    import shift_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int STEP = 1,
    localparam int SW   = clog2_f(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_data,
    input  logic [SW-1:0]   in_shamt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_illegal,
    output logic            busy
);

    localparam int          KW       = clog2_f(STEP) + 1;
    localparam logic [SW:0] STEP_EXT = (SW + 1)'(STEP);

    state_e          state_q;
    state_e          state_d;
    logic [XLEN-1:0] val_q;
    logic [2:0]      op_q;
    logic [SW-1:0]   rem_q;
    logic            ill_q;
    logic [SW:0]     k_full;
    logic [KW-1:0]   step_k;
    logic [XLEN-1:0] step_res;
    logic            accept;
    logic            last_step;

    assign accept    = in_valid && (state_q == ST_IDLE);
    assign k_full    = ({1'b0, rem_q} > STEP_EXT) ? STEP_EXT : {1'b0, rem_q};
    assign step_k    = k_full[KW-1:0];
    assign last_step = ({1'b0, rem_q} <= STEP_EXT);

    shift_step #(
        .XLEN(XLEN),
        .STEP(STEP)
    ) u_step (
        .value (val_q),
        .op    (op_q),
        .k     (step_k),
        .result(step_res)
    );

    // FSM state register; reset drops any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Capture the request on acceptance, then walk the shift down by k each SHIFT cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            val_q <= in_data;
            op_q  <= in_op;
            rem_q <= in_shamt;
            ill_q <= !op_legal(in_op);
        end else if (state_q == ST_SHIFT) begin
            val_q <= step_res;
            rem_q <= rem_q - k_full[SW-1:0];
        end
    end

    // Next-state and handshake outputs; result is only visible while DONE
    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_illegal = 1'b0;
        busy        = 1'b1;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid)
                    state_d = ((in_shamt != '0) && op_legal(in_op)) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                if (last_step) state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid   = 1'b1;
                out_data    = val_q;
                out_illegal = ill_q;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Bench for shift_seq_unit: five instances (STEP 1,2,4,8,32, XLEN 32) driven
// one at a time; results and latency are compared against an arithmetic model.
module tb_shift_seq_unit;

    localparam int ND = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid    [ND];
    logic        in_ready    [ND];
    logic [2:0]  in_op       [ND];
    logic [31:0] in_data     [ND];
    logic [4:0]  in_shamt    [ND];
    logic        out_valid   [ND];
    logic        out_ready   [ND];
    logic [31:0] out_data    [ND];
    logic        out_illegal [ND];
    logic        busy        [ND];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    function automatic int step_of(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            3:       return 8;
            default: return 32;
        endcase
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_dut
        shift_seq_unit #(
            .XLEN(32),
            .STEP(step_of(g))
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .in_op      (in_op[g]),
            .in_data    (in_data[g]),
            .in_shamt   (in_shamt[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_data   (out_data[g]),
            .out_illegal(out_illegal[g]),
            .busy       (busy[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit tb_legal(input logic [2:0] op);
        if (op <= 3'd2) return 1'b1;
`ifdef SHIFT_ROTATE_EN
        if (op == 3'd3 || op == 3'd4) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Reference: whole shift by s in one go using 64-bit arithmetic.
    function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [31:0] a,
                                              input int s);
        longint unsigned x;
        longint unsigned m;
        x = 64'(a);
        m = 64'hFFFF_FFFF;
        if (!tb_legal(op)) return a;
        case (op)
            3'd0: return 32'((x << s) & m);
            3'd1: return 32'(x >> s);
            3'd2: return a[31] ? 32'((x >> s) | (m ^ (m >> s))) : 32'(x >> s);
            3'd3: return 32'(((x << s) | (x >> (32 - s))) & m);
            3'd4: return 32'(((x >> s) | (x << (32 - s))) & m);
            default: return a;
        endcase
    endfunction

    task automatic run_req(input int d, input logic [2:0] op, input logic [31:0] a,
                           input int s, input int hold, input string tag);
        logic [31:0] exp;
        int          exp_lat;
        int          lat;
        exp     = ref_shift(op, a, s);
        exp_lat = (tb_legal(op) && s != 0) ? (s + step_of(d) - 1) / step_of(d) + 1 : 1;
        chk({tag, "_ready"}, 64'(in_ready[d]), 64'd1);
        in_valid[d] = 1'b1;
        in_op[d]    = op;
        in_data[d]  = a;
        in_shamt[d] = 5'(s);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        in_data[d]  = $urandom;
        in_op[d]    = 3'($urandom);
        in_shamt[d] = 5'($urandom);
        lat = 1;
        while (!out_valid[d] && lat < 100) begin
            out_ready[d] = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        out_ready[d] = 1'b0;
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_data"}, 64'(out_data[d]), 64'(exp));
        chk({tag, "_ill"}, 64'(out_illegal[d]), 64'(!tb_legal(op)));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_data"}, 64'(out_data[d]), 64'(exp));
            chk({tag, "_hold_rdy"}, 64'(in_ready[d]), 64'd0);
            chk({tag, "_hold_vld"}, 64'(out_valid[d]), 64'd1);
        end
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        chk({tag, "_idle_vld"}, 64'(out_valid[d]), 64'd0);
        chk({tag, "_idle_rdy"}, 64'(in_ready[d]), 64'd1);
    endtask

    initial begin
        int seen;
        logic [2:0] op;
        rst_n = 1'b0;
        for (int i = 0; i < ND; i++) begin
            in_valid[i]  = 1'b0;
            in_op[i]     = 3'd0;
            in_data[i]   = 32'd0;
            in_shamt[i]  = 5'd0;
            out_ready[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < ND; i++) begin
            chk("rst_vld", 64'(out_valid[i]), 64'd0);
            chk("rst_data", 64'(out_data[i]), 64'd0);
            chk("rst_ill", 64'(out_illegal[i]), 64'd0);
            chk("rst_busy", 64'(busy[i]), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < ND; i++) chk("rst_rdy", 64'(in_ready[i]), 64'd1);

        run_req(0, 3'd2, 32'hFFFF_FFFC, 1, 0, "sra_neg");
        run_req(2, 3'd1, 32'h8000_0000, 31, 0, "srl_31_s4");
        run_req(2, 3'd0, 32'h0000_0001, 0, 0, "sll_0_s4");
        run_req(1, 3'd4, 32'h0000_0001, 1, 0, "ror_1");
        run_req(0, 3'd3, 32'h8000_0001, 3, 0, "rol_3");
        run_req(3, 3'd2, 32'h1234_5678, 7, 5, "bp_sra");
        run_req(4, 3'd7, 32'hDEAD_BEEF, 9, 0, "illegal7");
        run_req(4, 3'd2, 32'h8000_0000, 31, 0, "sra_31_s32");

        // Abort a long shift with reset; no result may appear afterwards
        in_valid[0] = 1'b1;
        in_op[0]    = 3'd0;
        in_data[0]  = 32'h1;
        in_shamt[0] = 5'd20;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy", 64'(busy[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_vld", 64'(out_valid[0]), 64'd0);
        chk("async_busy", 64'(busy[0]), 64'd0);
        chk("async_data", 64'(out_data[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid[0]) seen++;
        end
        chk("abort_noresult", 64'(seen), 64'd0);
        run_req(0, 3'd0, 32'h3, 2, 0, "post_rst_sll");

        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 9) == 0) op = 3'($urandom_range(5, 7));
                else op = 3'($urandom_range(0, 4));
                run_req(d, op, $urandom, int'($urandom_range(0, 31)),
                        int'($urandom_range(0, 3)), "rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
